regfile_sb: RTL and testbench

Parametrised multi-port general-purpose register file with integrated write-back bypass and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the pipelined core. It sits between decode, which reads operands and issues destinations, and write-back, which retires results from one or more execution lanes. The scoreboard lets decode detect read-after-write hazards without a separate hazard unit.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_wr_arb.sv | 33 +++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default widths, the hardwired
// zero address and a slice-offset helper for flat packed port buses.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned ZERO_ADDR  = 0;

   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the register file: read ports, write ports, issue and stall.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2
);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     iss_vld;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_vld, iss_addr,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_vld, iss_addr,
      output rd_data, rd_busy, any_busy
   );

endinterface

// File: rtl/regfile_wr_arb.sv
// Per-address write resolution: which register is written this cycle and with whose data,
// highest-index port winning. Shared by the storage update and the bypass path.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_WR = 2
) (
   input  logic [NUM_WR-1:0]                i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]         i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]         i_wr_data,
   output logic [2**ADDR_W-1:0]             o_hit,
   output logic [2**ADDR_W-1:0][DATA_W-1:0] o_data
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   always_comb begin
      o_hit  = '0;
      o_data = '0;
      // Ascending scan, so a higher-index port overrides any lower one on the same address.
      for (int unsigned a = 0; a < DEPTH; a++) begin
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (i_wr_en[p] && (i_wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
               o_hit[a]  = 1'b1;
               o_data[a] = i_wr_data[slice_lo(p, DATA_W) +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard
// that flags read-after-write hazards to decode.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
   logic [DEPTH-1:0]              r_pend;
   logic [DEPTH-1:0]              w_hit;
   logic [DEPTH-1:0][DATA_W-1:0]  w_wdata;
   logic [DEPTH-1:0]              w_keep;
   logic [DEPTH-1:0]              w_iss;
   logic [NUM_RD-1:0][ADDR_W-1:0] w_rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]             w_rd_busy;

   regfile_wr_arb #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
   ) u_wr_arb (
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_hit     (w_hit),
      .o_data    (w_wdata)
   );

   assign w_rd_addr = bus.rd_addr;

   // w_keep is low only for the hardwired zero register.
   always_comb begin
      w_keep = '0;
      w_iss  = '0;
      for (int unsigned a = 0; a < DEPTH; a++) begin
         w_keep[a] = !(ZERO_REG && (a == ZERO_ADDR));
         w_iss[a]  = w_keep[a] && bus.iss_vld && (bus.iss_addr == ADDR_W'(a));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem  <= '0;
         r_pend <= '0;
      end else begin
         for (int unsigned a = 0; a < DEPTH; a++) begin
            if (w_hit[a] && w_keep[a]) begin
               r_mem[a] <= w_wdata[a];
            end
         end
         // Set beats clear: a fresh issue means a newer producer is still outstanding.
         r_pend <= w_iss | (r_pend & ~w_hit);
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_busy = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         w_rd_data[r] = r_mem[w_rd_addr[r]];
         w_rd_busy[r] = r_pend[w_rd_addr[r]];
         if (BYPASS && w_hit[w_rd_addr[r]]) begin
            w_rd_data[r] = w_wdata[w_rd_addr[r]];
            w_rd_busy[r] = 1'b0;
         end
         // Reset also masks bypassed write data presented while it is held.
         if (!w_keep[w_rd_addr[r]] || reset) begin
            w_rd_data[r] = '0;
            w_rd_busy[r] = 1'b0;
         end
      end
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_busy  = w_rd_busy;
   assign bus.any_busy = |w_rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build and a 3R/3W 64-bit build.
module tb_regfile_sb;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
   regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus_nb ();
   regfile_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3), .NUM_WR(3)) bus_w ();

   regfile_sb #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   regfile_sb #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
   ) u_dut_nb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_nb)
   );

   regfile_sb #(
      .DATA_W(64), .ADDR_W(5), .NUM_RD(3), .NUM_WR(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) u_dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w)
   );

   task automatic idle_all();
      bus.wr_en      = '0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.iss_vld    = 1'b0;
      bus.iss_addr   = '0;
      bus_nb.wr_en   = '0;
      bus_nb.wr_addr = '0;
      bus_nb.wr_data = '0;
      bus_nb.iss_vld = 1'b0;
      bus_nb.iss_addr = '0;
      bus_w.wr_en    = '0;
      bus_w.wr_addr  = '0;
      bus_w.wr_data  = '0;
      bus_w.iss_vld  = 1'b0;
      bus_w.iss_addr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_all();
      bus.rd_addr    = '0;
      bus_nb.rd_addr = '0;
      bus_w.rd_addr  = '0;
      #2;
      for (int a = 0; a < 32; a++) begin
         bus.rd_addr = {5'(a), 5'(31 - a)};
         #1;
         n_tests++;
         if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_read addr=%0d got data=%h busy=%b want 0/00",
                     a, bus.rd_data, bus.rd_busy);
         end
      end
      // Write and issue presented while reset is high must be lost.
      @(negedge clk);
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd1};
      bus.wr_data  = {32'd0, 32'h1111_1111};
      bus.iss_vld  = 1'b1;
      bus.iss_addr = 5'd1;
      bus.rd_addr  = {5'd1, 5'd1};
      #2;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.any_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_bypass_mask got data=%h any_busy=%b want 0/0",
                  bus.rd_data, bus.any_busy);
      end
      @(negedge clk);
      idle_all();
      reset = 1'b0;
      #2;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00 || bus.any_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_write_lost got data=%h busy=%b any=%b want 0/00/0",
                  bus.rd_data, bus.rd_busy, bus.any_busy);
      end
   endtask

   task automatic test_write_priority();
      @(negedge clk);
      bus.wr_en   = 2'b11;
      bus.wr_addr = {5'd5, 5'd5};
      bus.wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
      bus.rd_addr = {5'd0, 5'd5};
      #2;
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h1234_5678 || bus.rd_data[63:32] !== 32'd0) begin
         n_fail++;
         $display("FAIL prio_bypass got p0=%h p1=%h want 12345678/00000000",
                  bus.rd_data[31:0], bus.rd_data[63:32]);
      end
      @(negedge clk);
      idle_all();
      bus.rd_addr = {5'd5, 5'd5};
      #2;
      n_tests++;
      if (bus.rd_data !== {32'h1234_5678, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL prio_storage got %h want 1234567812345678", bus.rd_data);
      end
      // Single lane write, observed through storage only.
      @(negedge clk);
      bus.wr_en   = 2'b01;
      bus.wr_addr = {5'd0, 5'd6};
      bus.wr_data = {32'd0, 32'hCAFE_F00D};
      @(negedge clk);
      idle_all();
      bus.rd_addr = {5'd6, 5'd5};
      #2;
      n_tests++;
      if (bus.rd_data !== {32'hCAFE_F00D, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL single_write got %h want cafef00d12345678", bus.rd_data);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd0};
      bus.wr_data  = {32'd0, 32'hFFFF_FFFF};
      bus.iss_vld  = 1'b1;
      bus.iss_addr = 5'd0;
      bus.rd_addr  = {5'd0, 5'd0};
      #2;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
         n_fail++;
         $display("FAIL zero_same_cycle got data=%h busy=%b want 0/00", bus.rd_data, bus.rd_busy);
      end
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00 || bus.any_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_next_cycle got data=%h busy=%b any=%b want 0/00/0",
                  bus.rd_data, bus.rd_busy, bus.any_busy);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      bus.iss_vld  = 1'b1;
      bus.iss_addr = 5'd7;
      bus.rd_addr  = {5'd6, 5'd7};
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b00) begin
         n_fail++;
         $display("FAIL sb_issue_cycle got busy=%b want 00", bus.rd_busy);
      end
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b01 || bus.any_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_pending got busy=%b any=%b want 01/1", bus.rd_busy, bus.any_busy);
      end
      @(negedge clk);
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b01) begin
         n_fail++;
         $display("FAIL sb_hold got busy=%b want 01", bus.rd_busy);
      end
      @(negedge clk);
      bus.wr_en   = 2'b10;
      bus.wr_addr = {5'd7, 5'd0};
      bus.wr_data = {32'hA5A5_A5A5, 32'd0};
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b00 || bus.any_busy !== 1'b0 || bus.rd_data[31:0] !== 32'hA5A5_A5A5) begin
         n_fail++;
         $display("FAIL sb_wb_bypass got busy=%b any=%b data=%h want 00/0/a5a5a5a5",
                  bus.rd_busy, bus.any_busy, bus.rd_data[31:0]);
      end
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b00 || bus.rd_data[31:0] !== 32'hA5A5_A5A5) begin
         n_fail++;
         $display("FAIL sb_cleared got busy=%b data=%h want 00/a5a5a5a5",
                  bus.rd_busy, bus.rd_data[31:0]);
      end
   endtask

   task automatic test_set_wins();
      @(negedge clk);
      bus.iss_vld  = 1'b1;
      bus.iss_addr = 5'd9;
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd9};
      bus.wr_data  = {32'd0, 32'h0000_0099};
      bus.rd_addr  = {5'd0, 5'd9};
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b01 || bus.rd_data[31:0] !== 32'h0000_0099) begin
         n_fail++;
         $display("FAIL set_wins got busy=%b data=%h want 01/00000099",
                  bus.rd_busy, bus.rd_data[31:0]);
      end
      @(negedge clk);
      bus.wr_en   = 2'b01;
      bus.wr_addr = {5'd0, 5'd9};
      bus.wr_data = {32'd0, 32'h0000_0100};
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b00 || bus.rd_data[31:0] !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL set_wins_clear got busy=%b data=%h want 00/00000100",
                  bus.rd_busy, bus.rd_data[31:0]);
      end
   endtask

   task automatic test_no_bypass();
      @(negedge clk);
      bus_nb.iss_vld  = 1'b1;
      bus_nb.iss_addr = 5'd7;
      bus_nb.rd_addr  = {5'd0, 5'd7};
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus_nb.rd_busy !== 2'b01 || bus_nb.any_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nb_pending got busy=%b any=%b want 01/1", bus_nb.rd_busy, bus_nb.any_busy);
      end
      @(negedge clk);
      bus_nb.wr_en   = 2'b01;
      bus_nb.wr_addr = {5'd0, 5'd7};
      bus_nb.wr_data = {32'd0, 32'hA5A5_A5A5};
      #2;
      n_tests++;
      if (bus_nb.rd_busy !== 2'b01 || bus_nb.rd_data[31:0] !== 32'd0) begin
         n_fail++;
         $display("FAIL nb_write_cycle got busy=%b data=%h want 01/00000000",
                  bus_nb.rd_busy, bus_nb.rd_data[31:0]);
      end
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus_nb.rd_busy !== 2'b00 || bus_nb.any_busy !== 1'b0 ||
          bus_nb.rd_data[31:0] !== 32'hA5A5_A5A5) begin
         n_fail++;
         $display("FAIL nb_after_write got busy=%b any=%b data=%h want 00/0/a5a5a5a5",
                  bus_nb.rd_busy, bus_nb.any_busy, bus_nb.rd_data[31:0]);
      end
   endtask

   task automatic test_wide();
      logic [63:0] exp_d [3];
      @(negedge clk);
      bus_w.wr_en   = 3'b111;
      bus_w.wr_addr = {5'd3, 5'd3, 5'd3};
      bus_w.wr_data = {64'h3333_4444_5555_6666, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      bus_w.rd_addr = {5'd3, 5'd3, 5'd3};
      #2;
      for (int r = 0; r < 3; r++) begin
         n_tests++;
         if (bus_w.rd_data[r*64 +: 64] !== 64'h3333_4444_5555_6666) begin
            n_fail++;
            $display("FAIL wide_bypass port=%0d got %h want 3333444455556666",
                     r, bus_w.rd_data[r*64 +: 64]);
         end
      end
      @(negedge clk);
      bus_w.wr_en   = 3'b011;
      bus_w.wr_addr = {5'd0, 5'd4, 5'd4};
      bus_w.wr_data = {64'd0, 64'hBBBB_0000_BBBB_0000, 64'hAAAA_0000_AAAA_0000};
      bus_w.rd_addr = {5'd4, 5'd3, 5'd4};
      exp_d[0] = 64'hBBBB_0000_BBBB_0000;
      exp_d[1] = 64'h3333_4444_5555_6666;
      exp_d[2] = 64'hBBBB_0000_BBBB_0000;
      #2;
      for (int r = 0; r < 3; r++) begin
         n_tests++;
         if (bus_w.rd_data[r*64 +: 64] !== exp_d[r]) begin
            n_fail++;
            $display("FAIL wide_mixed port=%0d got %h want %h", r, bus_w.rd_data[r*64 +: 64], exp_d[r]);
         end
      end
      @(negedge clk);
      idle_all();
      #2;
      for (int r = 0; r < 3; r++) begin
         n_tests++;
         if (bus_w.rd_data[r*64 +: 64] !== exp_d[r]) begin
            n_fail++;
            $display("FAIL wide_storage port=%0d got %h want %h", r, bus_w.rd_data[r*64 +: 64], exp_d[r]);
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      bus.iss_vld  = 1'b1;
      bus.iss_addr = 5'd12;
      bus.rd_addr  = {5'd12, 5'd5};
      @(negedge clk);
      idle_all();
      #2;
      n_tests++;
      if (bus.rd_busy !== 2'b10 || bus.rd_data[31:0] !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL pre_reset got busy=%b data=%h want 10/12345678",
                  bus.rd_busy, bus.rd_data[31:0]);
      end
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00 || bus.any_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got data=%h busy=%b any=%b want 0/00/0",
                  bus.rd_data, bus.rd_busy, bus.any_busy);
      end
      @(negedge clk);
      reset = 1'b0;
      #2;
      n_tests++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
         n_fail++;
         $display("FAIL post_reset got data=%h busy=%b want 0/00", bus.rd_data, bus.rd_busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_priority();
      test_zero_reg();
      test_scoreboard();
      test_set_wins();
      test_no_bypass();
      test_wide();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
